// File: rtl/i2c_slave_ram_port.sv
// rtl/i2c_slave_ram_port.sv - I2C slave responder bridging bus transfers to the RAM controller ports
//
// Purpose:
//   Remote master writes a RAM pointer byte followed by data bytes, which are
//   pushed out through the remote-RAM write port. Remote master reads return
//   bytes fetched through the local-RAM read port. The RAM pointer persists
//   across transactions and wraps modulo 2^ADDR_W.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   scl_in/sda_in - raw bus lines from the pads
//   sda_oe        - 1 pulls SDA low (open-drain)
//   slave_addr    - own 7-bit address, captured at each START
//   ram_wadd/ram_din/ram_w - remote-RAM write port (one-clk strobe)
//   ram_radd/ram_dout      - local-RAM read port (data valid 1 clk later)
//   busy          - addressed transaction in progress
//   xfer_done     - one-clk pulse at the STOP that ends an addressed transaction

module i2c_slave_ram_port #(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [6:0]        slave_addr,
  output logic [ADDR_W-1:0] ram_wadd,
  output logic [7:0]        ram_din,
  output logic              ram_w,
  output logic [ADDR_W-1:0] ram_radd,
  input  logic [7:0]        ram_dout,
  output logic              busy,
  output logic              xfer_done
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    WPTR      = 4'd3,
    WDATA     = 4'd4,
    RX_ACK    = 4'd5,
    RDATA     = 4'd6,
    RACK      = 4'd7,
    WAIT_STOP = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;

  // Synchronizers reset to the idle bus level so reset release cannot
  // fabricate an edge on a quiet bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_in;
      sda_sync_q[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic sda_rise;
  logic sda_fall;
  logic start_det;
  logic stop_det;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise =  scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s &  scl_hist_q;
  assign sda_rise =  sda_s & ~sda_hist_q;
  assign sda_fall = ~sda_s &  sda_hist_q;

  // SCL must be high both before and after the SDA edge, so an SDA change
  // landing on the same clock as an SCL edge is not taken as a condition.
  assign start_det = sda_fall & scl_s & scl_hist_q;
  assign stop_det  = sda_rise & scl_s & scl_hist_q;

  // ---------------------------------------------------------------------
  // Protocol state machine
  // ---------------------------------------------------------------------
  state_t             state_q;
  logic [3:0]         bit_cnt_q;
  logic [7:0]         rx_q;
  logic               rx_full_q;
  logic [7:0]         tx_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [6:0]         addr_q;
  logic               rw_q;
  logic               mack_q;
  logic               sda_oe_q;
  logic               ram_w_q;
  logic [ADDR_W-1:0]  ram_wadd_q;
  logic [7:0]         ram_din_q;
  logic               busy_q;
  logic               xfer_done_q;

  logic [7:0]         rx_byte_d;

  // Byte as it will stand once the bit arriving on this scl_rise is shifted in.
  assign rx_byte_d = {rx_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      rx_q        <= 8'd0;
      rx_full_q   <= 1'b0;
      tx_q        <= 8'd0;
      ptr_q       <= '0;
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      ram_w_q     <= 1'b0;
      ram_wadd_q  <= '0;
      ram_din_q   <= 8'd0;
      busy_q      <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      ram_w_q     <= 1'b0;
      xfer_done_q <= 1'b0;

      if (stop_det) begin
        state_q     <= IDLE;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b0;
        rx_full_q   <= 1'b0;
        xfer_done_q <= busy_q;
      end else if (start_det) begin
        // A (repeated) START abandons whatever byte was in flight.
        state_q   <= ADDR;
        bit_cnt_q <= 4'd0;
        rx_full_q <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        addr_q    <= slave_addr;
      end else begin
        case (state_q)
          IDLE: begin
          end

          ADDR: begin
            if (scl_rise) begin
              rx_q      <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                // Address 0 (general call) is never answered.
                if ((rx_byte_d[7:1] == addr_q) && (addr_q != 7'd0)) begin
                  busy_q  <= 1'b1;
                  rw_q    <= rx_byte_d[0];
                  state_q <= ADDR_ACK;
                end else begin
                  state_q <= IDLE;
                end
              end
            end
          end

          // sda_oe doubles as the phase flag: the first fall opens the ACK
          // slot, the second fall closes it.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else if (rw_q) begin
                tx_q      <= {ram_dout[6:0], 1'b0};
                sda_oe_q  <= ~ram_dout[7];
                bit_cnt_q <= 4'd1;
                ptr_q     <= ptr_q + PTR_ONE;
                state_q   <= RDATA;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                rx_full_q <= 1'b0;
                state_q   <= WPTR;
              end
            end
          end

          WPTR, WDATA: begin
            if (scl_rise && !rx_full_q) begin
              rx_q      <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                rx_full_q <= 1'b1;
              end
            end else if (scl_fall && rx_full_q) begin
              // Byte is committed only at the fall after bit 8, so an early
              // STOP/START leaves RAM untouched.
              if (state_q == WPTR) begin
                ptr_q <= rx_q[ADDR_W-1:0];
              end else begin
                ram_wadd_q <= ptr_q;
                ram_din_q  <= rx_q;
                ram_w_q    <= 1'b1;
                ptr_q      <= ptr_q + PTR_ONE;
              end
              sda_oe_q  <= 1'b1;
              rx_full_q <= 1'b0;
              bit_cnt_q <= 4'd0;
              state_q   <= RX_ACK;
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= WDATA;
            end
          end

          // bit_cnt counts bits already placed on SDA; the ninth fall
          // releases the line for the master's ACK.
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                mack_q   <= 1'b0;
                state_q  <= RACK;
              end else begin
                sda_oe_q  <= ~tx_q[7];
                tx_q      <= {tx_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          RACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                mack_q <= 1'b1;
              end else begin
                state_q <= WAIT_STOP;
              end
            end else if (scl_fall && mack_q) begin
              mack_q    <= 1'b0;
              tx_q      <= {ram_dout[6:0], 1'b0};
              sda_oe_q  <= ~ram_dout[7];
              bit_cnt_q <= 4'd1;
              ptr_q     <= ptr_q + PTR_ONE;
              state_q   <= RDATA;
            end
          end

          WAIT_STOP: begin
          end

          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign ram_wadd  = ram_wadd_q;
  assign ram_din   = ram_din_q;
  assign ram_w     = ram_w_q;
  assign ram_radd  = ptr_q;
  assign busy      = busy_q;
  assign xfer_done = xfer_done_q;

endmodule

// File: tb/tb_i2c_slave_ram_port.sv
// tb/tb_i2c_slave_ram_port.sv - bench for the I2C slave RAM port
//
// Purpose: drives the bus as a remote master, models the local RAM with one
// clock of read latency, and checks writes, read data, ACKs, busy, xfer_done
// and the RAM pointer against a transaction-level reference model.

module tb_i2c_slave_ram_port;

  localparam int Q = 5;  // quarter SCL period in clk cycles (SCL = clk/20)

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [6:0] slave_addr;
  logic [4:0] ram_wadd;
  logic [7:0] ram_din;
  logic       ram_w;
  logic [4:0] ram_radd;
  logic [7:0] ram_dout;
  logic       busy;
  logic       xfer_done;

  // Open-drain bus: low if either side pulls it low.
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_ram_port #(.ADDR_W(5), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .slave_addr (slave_addr),
    .ram_wadd   (ram_wadd),
    .ram_din    (ram_din),
    .ram_w      (ram_w),
    .ram_radd   (ram_radd),
    .ram_dout   (ram_dout),
    .busy       (busy),
    .xfer_done  (xfer_done)
  );

  logic [7:0] lram [32];
  always @(posedge clk) ram_dout <= lram[ram_radd];

  // Monitors: each is the only writer of its variables.
  logic [12:0] wq [$];
  int          xfer_cnt = 0;
  int          oe_cnt   = 0;
  always @(negedge clk) begin
    if (ram_w === 1'b1) wq.push_back({ram_wadd, ram_din});
    if (xfer_done === 1'b1) xfer_cnt++;
    if (sda_oe === 1'b1) oe_cnt++;
  end

  int errors = 0;
  int checks = 0;
  int mptr   = 0;   // reference model pointer

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2*Q);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    s = sda_in;   tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(~ack, s);
  endtask

  typedef struct packed {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  ptr;
    logic [2:0]  n;
    logic [31:0] data;     // byte i at data[8*i +: 8]
    logic        exp_ack;
  } txn_t;

  // Full transaction against the reference model: a matched write sets the
  // pointer from the first byte and stores each following byte at
  // pointer++ (mod 32); a matched read returns lram[pointer++]; an unmatched
  // transaction changes nothing and the bus reads as released (0xFF).
  task automatic run_txn(input txn_t t, input string tag);
    logic        ack;
    logic [7:0]  b;
    logic [7:0]  expb;
    logic [12:0] expw [$];
    int          wbase, xbase, obase;
    wbase = wq.size();
    xbase = xfer_cnt;
    obase = oe_cnt;
    i2c_start();
    send_byte({t.addr, t.rw}, ack);
    check($sformatf("%s addr_ack", tag), {31'd0, ack}, {31'd0, t.exp_ack});
    check($sformatf("%s busy_mid", tag), {31'd0, busy}, {31'd0, t.exp_ack});
    if (!t.rw) begin
      send_byte(t.ptr, ack);
      check($sformatf("%s ptr_ack", tag), {31'd0, ack}, {31'd0, t.exp_ack});
      if (t.exp_ack) mptr = int'(t.ptr) % 32;
      for (int i = 0; i < int'(t.n); i++) begin
        send_byte(t.data[8*i +: 8], ack);
        check($sformatf("%s data_ack%0d", tag, i), {31'd0, ack}, {31'd0, t.exp_ack});
        if (t.exp_ack) begin
          expw.push_back({5'(mptr), t.data[8*i +: 8]});
          mptr = (mptr + 1) % 32;
        end
      end
    end else begin
      for (int i = 0; i < int'(t.n); i++) begin
        expb = t.exp_ack ? lram[mptr] : 8'hFF;
        recv_byte(i != int'(t.n) - 1, b);
        check($sformatf("%s rdata%0d", tag, i), {24'd0, b}, {24'd0, expb});
        if (t.exp_ack) mptr = (mptr + 1) % 32;
      end
    end
    i2c_stop();
    check($sformatf("%s wr_count", tag), 32'(wq.size() - wbase), 32'(expw.size()));
    for (int i = 0; i < expw.size() && wbase + i < wq.size(); i++)
      check($sformatf("%s wr%0d", tag, i), {19'd0, wq[wbase + i]}, {19'd0, expw[i]});
    check($sformatf("%s xfer_done", tag), 32'(xfer_cnt - xbase), t.exp_ack ? 32'd1 : 32'd0);
    check($sformatf("%s pointer", tag), {27'd0, ram_radd}, 32'(mptr));
    check($sformatf("%s busy_end", tag), {31'd0, busy}, 32'd0);
    if (!t.exp_ack)
      check($sformatf("%s oe_quiet", tag), 32'(oe_cnt - obase), 32'd0);
  endtask

  txn_t       tbl [7];
  txn_t       rt;
  logic       ack;
  logic       s;
  logic [7:0] b;
  int         wbase, xbase;

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; slave_addr = 7'h42;
    for (int i = 0; i < 32; i++) lram[i] = 8'($urandom);
    lram[7] = 8'h3C;
    lram[8] = 8'hC3;

    tbl[0] = '{rw:1'b0, addr:7'h42, ptr:8'h05, n:3'd2, data:32'h0000_B2A1, exp_ack:1'b1};
    tbl[1] = '{rw:1'b1, addr:7'h42, ptr:8'h00, n:3'd2, data:32'h0,         exp_ack:1'b1};
    tbl[2] = '{rw:1'b0, addr:7'h42, ptr:8'h1F, n:3'd2, data:32'h0000_2211, exp_ack:1'b1};
    tbl[3] = '{rw:1'b1, addr:7'h42, ptr:8'h00, n:3'd1, data:32'h0,         exp_ack:1'b1};
    tbl[4] = '{rw:1'b0, addr:7'h48, ptr:8'h55, n:3'd0, data:32'h0,         exp_ack:1'b0};
    tbl[5] = '{rw:1'b0, addr:7'h00, ptr:8'h12, n:3'd1, data:32'h0000_0033, exp_ack:1'b0};
    tbl[6] = '{rw:1'b1, addr:7'h43, ptr:8'h00, n:3'd1, data:32'h0,         exp_ack:1'b0};

    tick(3);
    check("rst sda_oe",    {31'd0, sda_oe},    32'd0);
    check("rst ram_w",     {31'd0, ram_w},     32'd0);
    check("rst ram_wadd",  {27'd0, ram_wadd},  32'd0);
    check("rst ram_din",   {24'd0, ram_din},   32'd0);
    check("rst ram_radd",  {27'd0, ram_radd},  32'd0);
    check("rst busy",      {31'd0, busy},      32'd0);
    check("rst xfer_done", {31'd0, xfer_done}, 32'd0);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Repeated START: set pointer to 2, then read one byte in the same bus ownership.
    xbase = xfer_cnt;
    wbase = wq.size();
    i2c_start();
    send_byte(8'h84, ack); check("rs addr_w_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h02, ack); check("rs ptr_ack",    {31'd0, ack}, 32'd1);
    mptr = 2;
    i2c_start();
    send_byte(8'h85, ack); check("rs addr_r_ack", {31'd0, ack}, 32'd1);
    recv_byte(1'b0, b);    check("rs rdata",      {24'd0, b},   {24'd0, lram[2]});
    mptr = 3;
    i2c_stop();
    check("rs xfer_done", 32'(xfer_cnt - xbase), 32'd1);
    check("rs pointer",   {27'd0, ram_radd}, 32'(mptr));
    check("rs no_write",  32'(wq.size() - wbase), 32'd0);

    // Reset during bit 4 of a data byte.
    wbase = wq.size();
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h0A, ack);
    bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b1, s);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(2);
    check("abort busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("abort sda_oe",   {31'd0, sda_oe},   32'd0);
    check("abort busy",     {31'd0, busy},     32'd0);
    check("abort pointer",  {27'd0, ram_radd}, 32'd0);
    check("abort no_write", 32'(wq.size() - wbase), 32'd0);
    rst = 1'b0;
    mptr = 0;
    tick(Q);
    sda_m = 1'b1;
    tick(4*Q);
    rt = '{rw:1'b0, addr:7'h42, ptr:8'h03, n:3'd1, data:32'h0000_0077, exp_ack:1'b1};
    run_txn(rt, "post_abort");

    // Randomized transactions.
    for (int k = 0; k < 30; k++) begin
      rt.rw      = 1'($urandom_range(0, 1));
      rt.addr    = ($urandom_range(0, 3) != 0) ? 7'h42 : 7'($urandom);
      rt.ptr     = 8'($urandom);
      rt.n       = rt.rw ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 3));
      rt.data    = $urandom;
      rt.exp_ack = (rt.addr == slave_addr) && (rt.addr != 7'h0);
      run_txn(rt, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
